// File: rtl/bram_byte_sequencer.sv
// rtl/bram_byte_sequencer.sv - byte/half/word load-store sequencer for a byte-wide BRAM
module bram_byte_sequencer #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_mem_data,
  output logic                  o_mem_write,
  input  logic [7:0]            i_mem_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_base;      // address of byte 0
  logic [2:0]            r_nbytes;    // 1, 2 or 4
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [2:0]            r_cnt;       // cycles elapsed since the accept edge
  logic [31:0]           r_wshift;    // remaining store bytes, next one in [31:24]
  logic [23:0]           r_acc;       // load bytes captured so far, newest in [7:0]
  logic                  r_busy;
  logic                  r_done;
  logic [31:0]           r_rdata;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_data;
  logic                  r_mem_write;

  logic                  w_accept;
  logic [2:0]            w_nbytes;
  logic [31:0]           w_wdata_aligned;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic                  w_last_write;
  logic                  w_read_final;
  logic                  w_read_issue;
  logic                  w_read_capture;
  logic [31:0]           w_acc_next;
  logic [31:0]           w_load_result;
  logic                  w_unused;

  // Upper address bits are ignored: addresses wrap inside the BRAM.
  assign w_unused = &{1'b0, i_addr[31:ADDR_WIDTH]};

  assign w_accept = i_req && (r_state == S_IDLE);

  // Byte count and left-aligned store value (first byte to send sits in [31:24]).
  always_comb begin
    w_nbytes        = 3'd4;
    w_wdata_aligned = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        w_nbytes        = 3'd1;
        w_wdata_aligned = {i_wdata[7:0], 24'h000000};
      end
      SZ_HALF: begin
        w_nbytes        = 3'd2;
        w_wdata_aligned = {i_wdata[15:0], 16'h0000};
      end
      default: begin
        w_nbytes        = 3'd4;
        w_wdata_aligned = i_wdata;
      end
    endcase
  end

  // r_cnt equals k at edge E0+k, so it doubles as the byte index to issue.
  assign w_issue_addr   = r_base + ADDR_WIDTH'(r_cnt);
  assign w_last_write   = (r_cnt == r_nbytes);
  assign w_read_issue   = (r_cnt < r_nbytes);
  assign w_read_capture = (r_cnt >= 3'd2);
  assign w_read_final   = (r_cnt == (r_nbytes + 3'd1));
  assign w_acc_next     = {r_acc, i_mem_data};

  // Sign/zero extension of the assembled big-endian value.
  always_comb begin
    w_load_result = w_acc_next;
    case (r_size)
      SZ_BYTE: w_load_result = r_unsigned ? {24'h000000, w_acc_next[7:0]}
                                          : {{24{w_acc_next[7]}}, w_acc_next[7:0]};
      SZ_HALF: w_load_result = r_unsigned ? {16'h0000, w_acc_next[15:0]}
                                          : {{16{w_acc_next[15]}}, w_acc_next[15:0]};
      default: w_load_result = w_acc_next;
    endcase
  end

  // Control FSM: request latch, cycle counter, busy/done handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_nbytes   <= 3'd0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_cnt      <= 3'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_base     <= i_addr[ADDR_WIDTH-1:0];
            r_nbytes   <= w_nbytes;
            r_size     <= i_size;
            r_unsigned <= i_unsigned;
            r_cnt      <= 3'd1;
            r_busy     <= 1'b1;
            r_state    <= i_we ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (w_last_write) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_READ: begin
          if (w_read_final) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  // BRAM port: one address per cycle; write enable only while storing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_addr  <= '0;
      r_mem_data  <= 8'h00;
      r_mem_write <= 1'b0;
      r_wshift    <= 32'h00000000;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mem_write <= 1'b0;
          if (w_accept) begin
            r_mem_addr <= i_addr[ADDR_WIDTH-1:0];
            if (i_we) begin
              r_mem_write <= 1'b1;
              r_mem_data  <= w_wdata_aligned[31:24];
              r_wshift    <= {w_wdata_aligned[23:0], 8'h00};
            end
          end
        end
        S_WRITE: begin
          if (w_last_write) begin
            r_mem_write <= 1'b0;
          end else begin
            r_mem_write <= 1'b1;
            r_mem_addr  <= w_issue_addr;
            r_mem_data  <= r_wshift[31:24];
            r_wshift    <= {r_wshift[23:0], 8'h00};
          end
        end
        S_READ: begin
          r_mem_write <= 1'b0;
          if (w_read_issue) begin
            r_mem_addr <= w_issue_addr;
          end
        end
        default: begin
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Load assembly: BRAM data for byte k arrives two edges after its address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc   <= 24'h000000;
      r_rdata <= 32'h00000000;
    end else begin
      if (w_accept && !i_we) begin
        r_acc <= 24'h000000;
      end else if ((r_state == S_READ) && w_read_capture) begin
        if (w_read_final) begin
          r_rdata <= w_load_result;
        end else begin
          r_acc <= w_acc_next[23:0];
        end
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_data  = r_mem_data;
  assign o_mem_write = r_mem_write;

endmodule

// File: tb/tb_bram_byte_sequencer.sv
// tb/tb_bram_byte_sequencer.sv - self-checking bench for bram_byte_sequencer
module tb_bram_byte_sequencer;

  localparam int AW    = 10;
  localparam int MEMSZ = 1 << AW;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req = 1'b0;
  logic          i_we = 1'b0;
  logic [1:0]    i_size = 2'b00;
  logic          i_unsigned = 1'b0;
  logic [31:0]   i_addr = 32'h0;
  logic [31:0]   i_wdata = 32'h0;
  logic          o_busy;
  logic          o_done;
  logic [31:0]   o_rdata;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    o_mem_data;
  logic          o_mem_write;
  logic [7:0]    i_mem_data;

  logic [7:0]    bram    [0:MEMSZ-1];
  logic [7:0]    ref_mem [0:MEMSZ-1];
  logic [31:0]   model_rdata;
  logic          clr = 1'b1;
  int            total = 0;
  int            bad = 0;

  bram_byte_sequencer #(.ADDR_WIDTH(AW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_size      (i_size),
    .i_unsigned  (i_unsigned),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_mem_addr  (o_mem_addr),
    .o_mem_data  (o_mem_data),
    .o_mem_write (o_mem_write),
    .i_mem_data  (i_mem_data)
  );

  always #5 i_clk = ~i_clk;

  // Byte-wide BRAM with registered read (read-before-write).
  always @(posedge i_clk) begin
    if (clr) begin
      for (int i = 0; i < MEMSZ; i++) bram[i] <= 8'h00;
    end else if (o_mem_write) begin
      bram[o_mem_addr] <= o_mem_data;
    end
    i_mem_data <= bram[o_mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [AW-1:0] byte_addr(input logic [31:0] a, input int k);
    return AW'((a + 32'(k)) % 32'(MEMSZ));
  endfunction

  // k-th most significant byte of the right-aligned n-byte store value
  function automatic logic [7:0] store_byte(input logic [31:0] wd, input int n, input int k);
    return 8'((wd >> (8 * (n - 1 - k))) % 256);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic uns);
    int n;
    logic [31:0] v;
    n = nbytes(s);
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v * 256 + 32'(ref_mem[byte_addr(a, k)]);
    if (!uns && n == 1 && v >= 32'h80) v = v + 32'hFFFFFF00;
    if (!uns && n == 2 && v >= 32'h8000) v = v + 32'hFFFF0000;
    return v;
  endfunction

  task automatic scramble(input bit hold);
    i_we       = 1'($urandom);
    i_size     = 2'($urandom);
    i_unsigned = 1'($urandom);
    i_addr     = $urandom;
    i_wdata    = $urandom;
    i_req      = hold ? 1'b1 : 1'($urandom);
  endtask

  // One request presented at the next edge; checks every cycle up to o_done.
  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    int n;
    int lat;
    logic [31:0] exp_r;
    n   = nbytes(size);
    lat = we ? n : n + 1;
    @(negedge i_clk);
    i_req = 1'b1; i_we = we; i_size = size; i_unsigned = uns; i_addr = addr; i_wdata = wdata;
    @(posedge i_clk); #1;
    scramble(hold);
    for (int c = 0; c < lat; c++) begin
      chk("busy_during", 32'(o_busy), 32'd1);
      chk("done_early", 32'(o_done), 32'd0);
      if (c < n) begin
        chk("mem_addr", 32'(o_mem_addr), 32'(byte_addr(addr, c)));
        chk("mem_write", 32'(o_mem_write), 32'(we));
        if (we) chk("mem_data", 32'(o_mem_data), 32'(store_byte(wdata, n, c)));
      end else begin
        chk("mem_write_tail", 32'(o_mem_write), 32'd0);
      end
      @(posedge i_clk); #1;
      scramble(hold);
    end
    i_req = 1'b0;
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("busy_at_done", 32'(o_busy), 32'd0);
    chk("write_at_done", 32'(o_mem_write), 32'd0);
    if (we) begin
      for (int k = 0; k < n; k++) ref_mem[byte_addr(addr, k)] = store_byte(wdata, n, k);
      chk("rdata_kept", o_rdata, model_rdata);
      for (int k = 0; k < n; k++)
        chk("bram_byte", 32'(bram[byte_addr(addr, k)]), 32'(ref_mem[byte_addr(addr, k)]));
    end else begin
      exp_r = ref_load(addr, size, uns);
      model_rdata = exp_r;
      chk("rdata", o_rdata, exp_r);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'h00;
    model_rdata = 32'h0;

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_data", 32'(o_mem_data), 32'd0);
    chk("rst_write", 32'(o_mem_write), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    clr   = 1'b0;

    // Word load of big-endian bytes FF,D0,07,93
    txn(1'b1, 2'd2, 1'b0, 32'h0, 32'hFFD00793, 1'b0);
    txn(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("t1_word", o_rdata, 32'hFFD00793);

    // Sign and zero extension
    txn(1'b1, 2'd0, 1'b0, 32'h10, 32'h123456FD, 1'b0);
    txn(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("t2_lb", o_rdata, 32'hFFFFFFFD);
    txn(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b0);
    chk("t2_lbu", o_rdata, 32'h000000FD);
    txn(1'b1, 2'd1, 1'b0, 32'h20, 32'hABCD8001, 1'b0);
    txn(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("t2_lh", o_rdata, 32'hFFFF8001);
    txn(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 1'b0);
    chk("t2_lhu", o_rdata, 32'h00008001);

    // Word store then overlapping unaligned half store
    txn(1'b1, 2'd2, 1'b0, 32'h100, 32'h41424344, 1'b0);
    chk("t3_rdata_kept", o_rdata, 32'h00008001);
    txn(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000BEEF, 1'b0);
    txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b0);
    chk("t3_merge", o_rdata, 32'h41BEEF44);

    // Address wrap
    txn(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h11223344, 1'b0);
    chk("t4_b3fe", 32'(bram[10'h3FE]), 32'h11);
    chk("t4_b001", 32'(bram[10'h001]), 32'h44);
    txn(1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0, 1'b0);
    chk("t4_wrap", o_rdata, 32'h11223344);

    // Request held while busy, then a back-to-back store
    txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1);
    txn(1'b1, 2'd0, 1'b0, 32'h30, 32'h0000005A, 1'b0);

    // Reset in the middle of a word store
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b1; i_size = 2'd2; i_addr = 32'h200; i_wdata = 32'hCAFEF00D;
    @(posedge i_clk); #1;
    i_req = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    #1;
    chk("t6_write_drop", 32'(o_mem_write), 32'd0);
    chk("t6_busy_drop", 32'(o_busy), 32'd0);
    chk("t6_rdata_clr", o_rdata, 32'd0);
    model_rdata = 32'h0;
    ref_mem[10'h200] = 8'hCA;
    ref_mem[10'h201] = 8'hFE;
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("t6_no_done", 32'(o_done), 32'd0);
    end
    for (int k = 0; k < 4; k++)
      chk("t6_bram", 32'(bram[10'h200 + AW'(k)]), 32'(ref_mem[10'h200 + AW'(k)]));
    txn(1'b0, 2'd0, 1'b1, 32'h201, 32'h0, 1'b0);
    chk("t6_lbu", o_rdata, 32'h000000FE);

    // Randomised traffic concentrated on a low window and the wrap point
    for (int t = 0; t < 80; t++) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 1) a = (r & 32'hFFFFFC00) | 32'($urandom_range(0, 48));
      else a = (r & 32'hFFFFFC00) | 32'($urandom_range(10'h3F8, 10'h3FF));
      txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge i_clk); #1;
        chk("idle_done", 32'(o_done), 32'd0);
        chk("idle_write", 32'(o_mem_write), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
